// File: rtl/resamp_rate_ctrl_pkg.sv
// Shared types and constants for the resampler rate controller.
// State encoding, accumulator width and default output widths.
package resamp_rate_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    localparam int PHASE_W   = 32;
    localparam int MU_W_DEF  = 18;
    localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/resamp_tgl_sync.sv
// Rate-word handoff from the register domain: 2-FF toggle sync, edge detect, shadow capture.
// new_rate is high 2 clk after the toggle; the shadow loads 3 clk after it. No backpressure.
module resamp_tgl_sync
    import resamp_rate_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               rate_tgl,
    input  logic [PHASE_W-1:0] rate_in,
    output logic [PHASE_W-1:0] shadow,
    output logic               new_rate
);

    logic               sync1_q;
    logic               sync2_q;
    logic               sync3_q;
    logic [1:0]         warm_q;
    logic [PHASE_W-1:0] shadow_q;

    // Detect is masked until the chain has reloaded the live toggle level after reset,
    // so a toggle left high across reset is not taken for a fresh write.
    assign new_rate = (sync2_q ^ sync3_q) & (warm_q == 2'd3);
    assign shadow   = shadow_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            sync3_q  <= 1'b0;
            warm_q   <= 2'd0;
            shadow_q <= '0;
        end else begin
            sync1_q <= rate_tgl;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            if (warm_q != 2'd3) begin
                warm_q <= warm_q + 2'd1;
            end
            if (new_rate) begin
                shadow_q <= rate_in;
            end
        end
    end

endmodule

// File: rtl/resamp_rate_ctrl.sv
// Resampler sequencer: phase accumulator stepped by rate_active, issuing clkEn_out and mu.
// clkEn_out/mu registered 1 clk after clkEn_in; no backpressure, at most one strobe per input.
module resamp_rate_ctrl
    import resamp_rate_ctrl_pkg::*;
#(
    parameter int MU_W  = MU_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic               flush,
    input  logic               clkEn_in,
    input  logic [PHASE_W-1:0] rate_in,
    input  logic               rate_tgl,
    output logic               clkEn_out,
    output logic [MU_W-1:0]    mu,
    output logic [PHASE_W-1:0] rate_active,
    output logic               rate_pending,
    output logic               run,
    output logic [CNT_W-1:0]   out_count
);

    state_e             state_q;
    logic [PHASE_W-1:0] phase_q;
    logic [PHASE_W-1:0] rate_q;
    logic               pend_q;
    logic               clken_q;
    logic [MU_W-1:0]    mu_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [PHASE_W-1:0] shadow;
    logic               new_rate;
    logic [PHASE_W:0]   sum_d;

    resamp_tgl_sync u_tgl_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .rate_tgl (rate_tgl),
        .rate_in  (rate_in),
        .shadow   (shadow),
        .new_rate (new_rate)
    );

    assign sum_d = {1'b0, phase_q} + {1'b0, rate_q};

    assign clkEn_out    = clken_q;
    assign mu           = mu_q;
    assign rate_active  = rate_q;
    assign rate_pending = pend_q;
    assign run          = (state_q == ST_RUN);
    assign out_count    = cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
            rate_q  <= '0;
            pend_q  <= 1'b0;
            clken_q <= 1'b0;
            mu_q    <= '0;
            cnt_q   <= '0;
        end else begin
            clken_q <= 1'b0;
            if (new_rate) begin
                pend_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    phase_q <= '0;
                    // A detect arriving in the same cycle keeps pending set for the newer word.
                    if (pend_q) begin
                        rate_q <= shadow;
                        if (!new_rate) begin
                            pend_q <= 1'b0;
                        end
                    end
                    if (enable) begin
                        state_q <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    phase_q <= '0;
                    if (!enable) begin
                        state_q <= ST_IDLE;
                    end else if (clkEn_in) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!enable) begin
                        state_q <= ST_IDLE;
                        phase_q <= '0;
                    end else if (flush) begin
                        phase_q <= '0;
                    end else if (clkEn_in) begin
                        phase_q <= sum_d[PHASE_W-1:0];
                        clken_q <= sum_d[PHASE_W];
                        mu_q    <= sum_d[PHASE_W-1 -: MU_W];
                        if (sum_d[PHASE_W]) begin
                            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                            // The wrapping step used the old rate; the new one takes the next step.
                            if (pend_q) begin
                                rate_q <= shadow;
                                if (!new_rate) begin
                                    pend_q <= 1'b0;
                                end
                            end
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    phase_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_resamp_rate_ctrl.sv
module tb_resamp_rate_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        flush = 1'b0;
    logic        clkEn_in = 1'b0;
    logic [31:0] rate_in = '0;
    logic        rate_tgl = 1'b0;
    logic        clkEn_out;
    logic [17:0] mu;
    logic [31:0] rate_active;
    logic        rate_pending;
    logic        run;
    logic [15:0] out_count;

    resamp_rate_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .flush        (flush),
        .clkEn_in     (clkEn_in),
        .rate_in      (rate_in),
        .rate_tgl     (rate_tgl),
        .clkEn_out    (clkEn_out),
        .mu           (mu),
        .rate_active  (rate_active),
        .rate_pending (rate_pending),
        .run          (run),
        .out_count    (out_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    typedef struct {
        int          due;
        logic [17:0] mu;
    } exp_t;
    exp_t q[$];

    // Reference accumulator model
    bit          m_run = 1'b0;
    logic [31:0] m_phase = '0;
    logic [31:0] m_rate = '0;
    logic [31:0] m_next = '0;
    bit          m_has_next = 1'b0;
    int          m_cnt = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit ce, input bit fl);
        logic [32:0] s;
        clkEn_in = ce;
        flush    = fl;
        if (fl && m_run) begin
            m_phase = '0;
        end else if (ce) begin
            if (!m_run) begin
                m_run = 1'b1;
            end else begin
                s = {1'b0, m_phase} + {1'b0, m_rate};
                m_phase = s[31:0];
                if (s[32]) begin
                    q.push_back('{due: cyc + 1, mu: s[31:14]});
                    m_cnt++;
                    if (m_has_next) begin
                        m_rate = m_next;
                        m_has_next = 1'b0;
                    end
                end
            end
        end
        tick();
        clkEn_in = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic set_rate_idle(input logic [31:0] r);
        enable = 1'b0;
        tick();
        rate_in  = r;
        rate_tgl = ~rate_tgl;
        repeat (5) tick();
        chk("idle_rate_active", 64'(rate_active), 64'(r));
        chk("idle_rate_pending", 64'(rate_pending), 64'd0);
        m_rate = r;
        m_phase = '0;
        m_run = 1'b0;
        m_has_next = 1'b0;
        enable = 1'b1;
        tick();
    endtask

    always @(negedge clk) begin
        bit exp_now;
        if (reset_n) begin
            exp_now = (q.size() > 0) && (q[0].due == cyc);
            if (clkEn_out || exp_now) begin
                chk("strobe", 64'(clkEn_out), 64'(exp_now));
                if (exp_now) begin
                    chk("mu", 64'(mu), 64'(q[0].mu));
                    void'(q.pop_front());
                end
            end
        end
    end

    int arm;
    bit tgl_done;

    initial begin
        #3;
        chk("rst_clkEn_out", 64'(clkEn_out), 64'd0);
        chk("rst_mu", 64'(mu), 64'd0);
        chk("rst_rate_active", 64'(rate_active), 64'd0);
        chk("rst_pending", 64'(rate_pending), 64'd0);
        chk("rst_run", 64'(run), 64'd0);
        chk("rst_count", 64'(out_count), 64'd0);
        #10;
        reset_n = 1'b1;
        repeat (5) tick();

        // Handshake timing in IDLE, then 0x80000000: strobe on every second RUN input
        rate_in  = 32'h8000_0000;
        rate_tgl = 1'b1;
        repeat (3) tick();
        chk("hs_pending_3clk", 64'(rate_pending), 64'd1);
        chk("hs_active_3clk", 64'(rate_active), 64'd0);
        tick();
        chk("hs_active_4clk", 64'(rate_active), 64'h8000_0000);
        chk("hs_pending_4clk", 64'(rate_pending), 64'd0);
        m_rate = 32'h8000_0000;
        enable = 1'b1;
        tick();
        chk("arm_run", 64'(run), 64'd0);
        drive(1'b1, 1'b0);
        chk("prime_run", 64'(run), 64'd1);
        chk("prime_no_out", 64'(clkEn_out), 64'd0);
        repeat (8) drive(1'b1, 1'b0);
        tick();
        chk("t1_count", 64'(out_count), 64'd4);

        // 0x40000000 with back-to-back inputs
        set_rate_idle(32'h4000_0000);
        drive(1'b1, 1'b0);
        repeat (16) drive(1'b1, 1'b0);
        tick();
        chk("t2_count", 64'(out_count), 64'(m_cnt[15:0]));

        // 0x60000000: mu at wraps carries the residue
        set_rate_idle(32'h6000_0000);
        drive(1'b1, 1'b0);
        repeat (12) drive(1'b1, 1'b0);
        tick();

        // Rate change requested mid-period applies at the next wrap
        set_rate_idle(32'h8000_0000);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        rate_in  = 32'h4000_0000;
        rate_tgl = ~rate_tgl;
        repeat (4) tick();
        chk("mid_pending", 64'(rate_pending), 64'd1);
        chk("mid_active_old", 64'(rate_active), 64'h8000_0000);
        m_next = 32'h4000_0000;
        m_has_next = 1'b1;
        repeat (9) drive(1'b1, 1'b0);
        tick();
        chk("mid_pending_clr", 64'(rate_pending), 64'd0);
        chk("mid_active_new", 64'(rate_active), 64'h4000_0000);

        // Detect coincident with a wrap: applied one wrap later
        set_rate_idle(32'h8000_0000);
        drive(1'b1, 1'b0);
        arm = 0;
        tgl_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (!tgl_done && m_phase == 32'h8000_0000) begin
                rate_in  = 32'h4000_0000;
                rate_tgl = ~rate_tgl;
                arm = 3;
                tgl_done = 1'b1;
            end
            drive(1'b1, 1'b0);
            if (arm > 0) begin
                arm--;
                if (arm == 0) begin
                    chk("coinc_pending", 64'(rate_pending), 64'd1);
                    chk("coinc_active_old", 64'(rate_active), 64'h8000_0000);
                    m_next = 32'h4000_0000;
                    m_has_next = 1'b1;
                end
            end
        end
        tick();
        chk("coinc_active_new", 64'(rate_active), 64'h4000_0000);
        chk("coinc_pending_clr", 64'(rate_pending), 64'd0);

        // Flush wins over a coincident input that would have wrapped
        for (int k = 0; k < 4 && m_phase != 32'hC000_0000; k++) drive(1'b1, 1'b0);
        drive(1'b1, 1'b1);
        chk("flush_no_out", 64'(clkEn_out), 64'd0);
        chk("flush_run", 64'(run), 64'd1);
        repeat (5) drive(1'b1, 1'b0);

        // Enable drop mid-period clears phase
        for (int k = 0; k < 4 && m_phase != 32'hC000_0000; k++) drive(1'b1, 1'b0);
        enable   = 1'b0;
        clkEn_in = 1'b1;
        m_run    = 1'b0;
        m_phase  = '0;
        tick();
        clkEn_in = 1'b0;
        chk("endrop_out", 64'(clkEn_out), 64'd0);
        chk("endrop_run", 64'(run), 64'd0);
        enable = 1'b1;
        tick();
        drive(1'b1, 1'b0);
        repeat (5) drive(1'b1, 1'b0);
        tick();
        chk("pre_rst_count", 64'(out_count), 64'(m_cnt[15:0]));
        chk("q_empty", 64'(q.size()), 64'd0);

        // Reset during RUN with a toggle in flight
        rate_in  = 32'h1234_5678;
        rate_tgl = ~rate_tgl;
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        chk("mrst_clkEn_out", 64'(clkEn_out), 64'd0);
        chk("mrst_mu", 64'(mu), 64'd0);
        chk("mrst_rate_active", 64'(rate_active), 64'd0);
        chk("mrst_pending", 64'(rate_pending), 64'd0);
        chk("mrst_run", 64'(run), 64'd0);
        chk("mrst_count", 64'(out_count), 64'd0);
        q.delete();
        m_cnt = 0;
        m_rate = '0;
        m_phase = '0;
        m_run = 1'b0;
        m_has_next = 1'b0;
        enable = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (8) tick();
        chk("post_rst_active", 64'(rate_active), 64'd0);
        chk("post_rst_pending", 64'(rate_pending), 64'd0);
        chk("post_rst_run", 64'(run), 64'd0);

        // A fresh write after reset is still taken
        set_rate_idle(32'h4000_0000);
        drive(1'b1, 1'b0);
        repeat (8) drive(1'b1, 1'b0);
        repeat (2) tick();
        chk("final_count", 64'(out_count), 64'(m_cnt[15:0]));
        chk("final_q_empty", 64'(q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
